// File: rtl/patch_pkg.sv
// Shared geometry defaults and FSM encoding for the patchifier/unpatchifier pair.
package patch_pkg;

  localparam int CHANNEL_SIZE      = 8;
  localparam int NUM_CHANNELS      = 3;
  localparam int PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS;
  localparam int IMG_WIDTH         = 64;
  localparam int IMG_HEIGHT        = 64;
  localparam int PATCH_SIZE        = 16;
  localparam int PATCHES_IN_ROW    = IMG_WIDTH / PATCH_SIZE;
  localparam int TOTAL_NUM_PATCHES = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE);
  localparam int PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    DONE = 2'b10
  } state_t;

  // Index width that never collapses to zero bits for degenerate geometries.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/unpatchifier_if.sv
// Stream-in / image-out bundle between the decode path, the unpatchifier and its consumer.
interface unpatchifier_if
  import patch_pkg::*;
#(
  parameter int CHANNEL_SIZE = patch_pkg::CHANNEL_SIZE,
  parameter int NUM_CHANNELS = patch_pkg::NUM_CHANNELS,
  parameter int IMG_WIDTH    = patch_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT   = patch_pkg::IMG_HEIGHT
);
  localparam int PW = CHANNEL_SIZE * NUM_CHANNELS;

  logic                                          en;
  logic                                          in_valid;
  logic                                          in_ready;
  logic [PW-1:0]                                 in_pixel;
  logic                                          in_last;
  logic                                          output_taken;
  state_t                                        state;
  logic                                          err;
  logic [IMG_HEIGHT-1:0][IMG_WIDTH-1:0][PW-1:0]  image_out;

  modport master (
    output en, in_valid, in_pixel, in_last, output_taken,
    input  in_ready, state, err, image_out
  );

  modport slave (
    input  en, in_valid, in_pixel, in_last, output_taken,
    output in_ready, state, err, image_out
  );

endinterface

// File: rtl/patch_addr_gen.sv
// Patch/position counters and the image row/column they map to.
module patch_addr_gen
  import patch_pkg::*;
#(
  parameter int IMG_WIDTH  = patch_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = patch_pkg::IMG_HEIGHT,
  parameter int PATCH_SIZE = patch_pkg::PATCH_SIZE,
  localparam int PIR       = IMG_WIDTH / PATCH_SIZE,
  localparam int NPATCH    = PIR * (IMG_HEIGHT / PATCH_SIZE),
  localparam int PVS       = PATCH_SIZE * PATCH_SIZE,
  localparam int PB        = clog2_min1(NPATCH),
  localparam int QB        = clog2_min1(PVS),
  localparam int RB        = clog2_min1(IMG_HEIGHT),
  localparam int CB        = clog2_min1(IMG_WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [PB-1:0] patch_idx,
  output logic [QB-1:0] pos_idx,
  output logic [RB-1:0] r,
  output logic [CB-1:0] c,
  output logic          last_pos,
  output logic          last_beat
);

  logic [PB-1:0] patch_idx_q, patch_idx_d;
  logic [QB-1:0] pos_idx_q, pos_idx_d;

  assign patch_idx = patch_idx_q;
  assign pos_idx   = pos_idx_q;
  assign last_pos  = (pos_idx_q == QB'(PVS - 1));
  assign last_beat = last_pos && (patch_idx_q == PB'(NPATCH - 1));

  // Power-of-two PATCH_SIZE lets synthesis reduce these to bit slices.
  assign r = RB'((32'(patch_idx_q) / 32'(PIR)) * 32'(PATCH_SIZE) + 32'(pos_idx_q) / 32'(PATCH_SIZE));
  assign c = CB'((32'(patch_idx_q) % 32'(PIR)) * 32'(PATCH_SIZE) + 32'(pos_idx_q) % 32'(PATCH_SIZE));

  always_comb begin
    patch_idx_d = patch_idx_q;
    pos_idx_d   = pos_idx_q;
    if (clear) begin
      patch_idx_d = '0;
      pos_idx_d   = '0;
    end else if (advance) begin
      if (last_pos) begin
        pos_idx_d   = '0;
        patch_idx_d = last_beat ? '0 : patch_idx_q + PB'(1);
      end else begin
        pos_idx_d = pos_idx_q + QB'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      patch_idx_q <= '0;
      pos_idx_q   <= '0;
    end else begin
      patch_idx_q <= patch_idx_d;
      pos_idx_q   <= pos_idx_d;
    end
  end

endmodule

// File: rtl/unpatchifier.sv
// Reassembles a full image from a patch-major pixel stream and holds it for the consumer.
module unpatchifier
  import patch_pkg::*;
#(
  parameter int CHANNEL_SIZE = patch_pkg::CHANNEL_SIZE,
  parameter int NUM_CHANNELS = patch_pkg::NUM_CHANNELS,
  parameter int IMG_WIDTH    = patch_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT   = patch_pkg::IMG_HEIGHT,
  parameter int PATCH_SIZE   = patch_pkg::PATCH_SIZE
) (
  input  logic          clk,
  input  logic          reset,
  unpatchifier_if.slave bus
);

  localparam int PW     = CHANNEL_SIZE * NUM_CHANNELS;
  localparam int NPATCH = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE);
  localparam int PVS    = PATCH_SIZE * PATCH_SIZE;
  localparam int PB     = clog2_min1(NPATCH);
  localparam int QB     = clog2_min1(PVS);
  localparam int RB     = clog2_min1(IMG_HEIGHT);
  localparam int CB     = clog2_min1(IMG_WIDTH);

  typedef logic [IMG_HEIGHT-1:0][IMG_WIDTH-1:0][PW-1:0] image_t;

  state_t state_q, state_d;
  logic   err_q, err_d;
  image_t image_q, image_d;

  logic          clear, accept;
  logic [PB-1:0] patch_idx;
  logic [QB-1:0] pos_idx;
  logic [RB-1:0] row;
  logic [CB-1:0] col;
  logic          last_pos, last_beat;

  patch_addr_gen #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .PATCH_SIZE (PATCH_SIZE)
  ) u_addr (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .advance   (accept),
    .patch_idx (patch_idx),
    .pos_idx   (pos_idx),
    .r         (row),
    .c         (col),
    .last_pos  (last_pos),
    .last_beat (last_beat)
  );

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.state     = state_q;
  assign bus.err       = err_q;
  assign bus.image_out = image_q;
  assign accept        = (state_q == LOAD) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    image_d = image_q;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d = LOAD;
          err_d   = 1'b0;
          clear   = 1'b1;
        end
      end
      LOAD: begin
        if (accept) begin
          image_d[row][col] = bus.in_pixel;
          // in_last is only checked, never used to resync the counters.
          if (bus.in_last != last_pos) err_d = 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.output_taken) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      image_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      image_q <= image_d;
    end
  end

endmodule

// File: tb/tb_unpatchifier.sv
// Directed bench for an 8x8 image built from four 4x4 patches, with a per-beat write scoreboard.
module tb_unpatchifier;
  import patch_pkg::*;

  localparam int W   = 8;
  localparam int H   = 8;
  localparam int PS  = 4;
  localparam int PIR = W / PS;
  localparam int NP  = PIR * (H / PS);
  localparam int PV  = PS * PS;
  localparam int NB  = NP * PV;

  typedef logic [H-1:0][W-1:0][23:0] img_t;
  typedef struct {
    int          r;
    int          c;
    logic [23:0] val;
  } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total_cnt = 0;
  int   pass_cnt = 0;
  sb_t  sb_q[$];
  img_t exp_img;

  always #5 clk = ~clk;

  unpatchifier_if #(.CHANNEL_SIZE(8), .NUM_CHANNELS(3), .IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

  unpatchifier #(
    .CHANNEL_SIZE (8),
    .NUM_CHANNELS (3),
    .IMG_WIDTH    (W),
    .IMG_HEIGHT   (H),
    .PATCH_SIZE   (PS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected image built patch-by-patch, independent of the beat counters.
  task automatic build_expected();
    exp_img = '0;
    for (int pr = 0; pr < H / PS; pr++)
      for (int pc = 0; pc < PIR; pc++)
        for (int y = 0; y < PS; y++)
          for (int x = 0; x < PS; x++)
            exp_img[pr*PS + y][pc*PS + x] = 24'((pr*PIR + pc) * 16 + y*PS + x);
  endtask

  task automatic pulse_en();
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    check("en_to_load", 32'(bus.state), 32'(2'b01));
  endtask

  task automatic take_output();
    img_t held;
    held = bus.image_out;
    bus.output_taken = 1'b1;
    tick();
    bus.output_taken = 1'b0;
    check("taken_to_idle", 32'(bus.state), 32'(2'b00));
    check("image_held", 32'(bus.image_out === held), 32'd1);
  endtask

  // Streams beats 0..stop_at-1; stall drops in_valid every 3rd cycle, bad_beat flips in_last.
  task automatic run_stream(input bit stall, input int bad_beat, input int stop_at);
    int beat = 0;
    int cyc = 0;
    while (beat < stop_at && cyc < 400) begin
      int p = beat / PV;
      int q = beat % PV;
      bit v = !(stall && (cyc % 3 == 2));
      bus.in_valid = v;
      bus.in_pixel = 24'(p * 16 + q);
      bus.in_last  = (q == PV - 1) ^ (beat == bad_beat);
      if (v) sb_q.push_back('{r: (p / PIR) * PS + q / PS, c: (p % PIR) * PS + q % PS,
                              val: 24'(p * 16 + q)});
      tick();
      cyc++;
      if (v) begin
        sb_t e = sb_q.pop_front();
        beat++;
        check($sformatf("pix[%0d][%0d]", e.r, e.c), 32'(bus.image_out[e.r][e.c]), 32'(e.val));
        check("state_after_beat", 32'(bus.state), (beat == NB) ? 32'(2'b10) : 32'(2'b01));
        check("err_after_beat", 32'(bus.err), (bad_beat >= 0 && beat > bad_beat) ? 32'd1 : 32'd0);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("stream_budget", 32'(beat), 32'(stop_at));
  endtask

  initial begin
    bus.en = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    bus.in_last = 1'b0;
    bus.output_taken = 1'b0;
    build_expected();

    tick();
    tick();
    reset = 1'b0;
    repeat (5) tick();
    check("reset_state", 32'(bus.state), 32'(2'b00));
    check("reset_ready", 32'(bus.in_ready), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    check("reset_image", 32'(bus.image_out === '0), 32'd1);

    // Clean stream, no stalls.
    pulse_en();
    run_stream(1'b0, -1, NB);
    check("img_5_6", 32'(bus.image_out[5][6]), 32'((3 << 4) | 6));
    check("img_0_0", 32'(bus.image_out[0][0]), 32'd0);
    check("img_7_7", 32'(bus.image_out[7][7]), 32'((3 << 4) | 15));
    check("img_full_1", 32'(bus.image_out === exp_img), 32'd1);
    check("err_clean", 32'(bus.err), 32'd0);

    // DONE ignores en and in_valid.
    bus.en = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pixel = 24'hFFFFFF;
    repeat (4) begin
      tick();
      check("done_hold_state", 32'(bus.state), 32'(2'b10));
      check("done_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.en = 1'b0;
    bus.in_valid = 1'b0;
    check("done_image_stable", 32'(bus.image_out === exp_img), 32'd1);
    take_output();

    // Stalled stream.
    pulse_en();
    run_stream(1'b1, -1, NB);
    check("img_full_stall", 32'(bus.image_out === exp_img), 32'd1);
    take_output();

    // Wrong in_last on beat 5.
    pulse_en();
    run_stream(1'b0, 5, NB);
    check("err_sticky", 32'(bus.err), 32'd1);
    check("img_full_err", 32'(bus.image_out === exp_img), 32'd1);
    take_output();
    check("err_held_idle", 32'(bus.err), 32'd1);
    pulse_en();
    check("err_cleared_en", 32'(bus.err), 32'd0);

    // Reset in the middle of LOAD, then a full stream.
    run_stream(1'b0, -1, 30);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_state", 32'(bus.state), 32'(2'b00));
    check("midreset_image", 32'(bus.image_out === '0), 32'd1);
    check("midreset_ready", 32'(bus.in_ready), 32'd0);
    pulse_en();
    run_stream(1'b0, -1, NB);
    check("img_full_after_reset", 32'(bus.image_out === exp_img), 32'd1);
    take_output();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
